mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
//  Multicycle main control FSM for the 32-bit MIPS core; upstream of the ALU function decoder.
//  - Sequences fetch/decode/execute/memory/writeback from the instruction opcode.
//  - Drives datapath mux selects, write strobes and the 2-bit ALUOp (00 add, 01 sub, 10 decode funct).
//  - Stalls on a memory ready handshake.
// PARAMETERS
//  PERF_W  32  width of the retired-instruction counter (used only with MC_PERF_CNT_EN)
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  reset      in   1  asynchronous, active-high; clears state immediately
//  opcode     in   6  instr[31:26] from instruction register
//  zero       in   1  ALU zero flag (valid in BEQEX)
//  mem_ready  in   1  memory completes current access this cycle
//  mem_req    out  1  memory access in progress (FETCH, MEMRD, MEMWR)
//  mem_write  out  1  write access (MEMWR only)
//  ir_write   out  1  load instruction register
//  iord       out  1  0=PC addresses memory, 1=ALUOut
//  reg_dst    out  1  0=rt, 1=rd
//  mem_to_reg out  1  0=ALUOut, 1=MDR
//  reg_write  out  1  register file write strobe
//  alu_src_a  out  1  0=PC, 1=A
//  alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
//  alu_op     out  2  to ALU function decoder
//  pc_src     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  pc_en      out  1  pc_write | (branch & zero)
//  illegal_op out  1  one-cycle pulse in DECODE on unsupported opcode
//  retired    out  PERF_W  instructions completed (MC_PERF_CNT_EN only)
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
//  Opcodes: lw 100011, sw 101011, R 000000, beq 000100, addi 001000, j 000010.
//  FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00;
//    holds until mem_ready=1; in that cycle ir_write=1 and pc_en=1, next state DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute); next state by opcode:
//    lw/sw->MEMADR, R->RTYPEEX, beq->BEQEX, addi->ADDIEX, j->JEX, other->FETCH with illegal_op=1.
//  MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEMRD, sw->MEMWR.
//  MEMRD: mem_req=1, iord=1; holds until mem_ready, then MEMWB.
//  MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
//  MEMWR: mem_req=1, mem_write=1, iord=1; holds until mem_ready, then FETCH.
//  RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPEWB.
//  RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
//  BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero -> FETCH.
//  ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB. ADDIWB: reg_dst=0, reg_write=1 -> FETCH.
//  JEX: pc_src=10, pc_en=1 -> FETCH.
//  Outputs are combinational from state (plus mem_ready/zero qualification); unlisted outputs are 0.
//  Strobes (ir_write, pc_en, reg_write, mem_write) never assert while reset=1.
//  Reset: state=FETCH asynchronously; outputs then show FETCH decode with ir_write=pc_en=0 until mem_ready.
//  Reset mid-access abandons the access; no strobe from the aborted state is issued.
//  mem_ready outside a memory state is ignored.
//  Latency in cycles with mem_ready tied 1: lw 5, sw/R/addi 4, beq/j 3.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: retired is a PERF_W-bit counter, reset 0.
//    Increments by 1 on entry to FETCH from MEMWB, MEMWR(ready), RTYPEWB, BEQEX, ADDIWB, JEX.
//    Illegal ops are not counted; the counter wraps from all-ones to 0.
//  Undefined: the retired port is absent and no counter logic is built.
// STRUCTURE
//  Shared include mips_defs.vh holds the opcode constants, state encodings (4-bit localparams),
//    ALUOp codes and alu_src_b/pc_src encodings.
//  ALUOp codes in mips_defs.vh are shared with the ALU function decoder.
//  One sub-module, mc_ctrl_decode: purely combinational state(+opcode,zero,mem_ready)->outputs map.
//  The FSM register and next-state logic stay in mc_main_control.
// TESTING
//  1. reset pulse mid-MEMRD with mem_ready=0 -> state FETCH at once, reg_write=0 throughout, no strobes.
//  2. mem_ready=1 const, R-type (op 000000) -> 4 cycles; alu_op=10 in RTYPEEX; reg_write=1, reg_dst=1 in cycle 4.
//  3. lw, mem_ready low 3 cycles in FETCH and 2 in MEMRD -> ir_write/pc_en pulse once;
//     MEMWB reached after 10 cycles total, then mem_to_reg=1.
//  4. beq with zero=1 -> pc_en=1, pc_src=01 in BEQEX; zero=0 -> pc_en=0; both return to FETCH.
//  5. opcode 111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no reg_write.
//  6. MC_PERF_CNT_EN, PERF_W=4: 17 addi retired -> retired=1 (wrap); illegal op leaves count unchanged.

Source files
------------

// File: rtl/mc_main_control_pkg.sv
// mc_main_control_pkg: opcodes, state encodings, ALUOp and mux-select codes shared by the main control
// and the ALU function decoder, plus the bundled control-output type.
package mc_main_control_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
    } state_t;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } ctrl_t;
    function automatic logic op_legal(input logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction
endpackage

// File: rtl/mc_main_control_if.sv
// mc_main_control_if: control bus between the main control FSM (master) and the datapath (slave).
interface mc_main_control_if;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       mem_req, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       pc_en, illegal_op;
    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map from FSM state (qualified by opcode, zero, mem_ready) to control outputs.
module mc_ctrl_decode
    import mc_main_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       reset,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.illegal_op = !op_legal(opcode);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            RTYPEWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ADDIWB: ctrl.reg_write = 1'b1;
            JEX: begin
                ctrl.pc_src = PC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: ;
        endcase
        // reset must suppress strobes even though state already reads FETCH
        if (reset) begin
            ctrl.ir_write  = 1'b0;
            ctrl.pc_en     = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
        end
    end
endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS main control FSM stalling on a memory ready handshake.
// Defining MC_PERF_CNT_EN adds the PERF_W-bit retired-instruction counter port.
module mc_main_control
    import mc_main_control_pkg::*;
`ifdef MC_PERF_CNT_EN
    #(parameter int PERF_W = 32)
`endif
(
    input logic clk,
    input logic reset,
    mc_main_control_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] retired
`endif
);
    state_t state, next;
    ctrl_t  ctrl;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            FETCH:   next = bus.mem_ready ? DECODE : FETCH;
            DECODE:  next = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                            bus.opcode == OP_R    ? RTYPEEX :
                            bus.opcode == OP_BEQ  ? BEQEX :
                            bus.opcode == OP_ADDI ? ADDIEX :
                            bus.opcode == OP_J    ? JEX : FETCH;
            MEMADR:  next = bus.opcode == OP_SW ? MEMWR : MEMRD;
            MEMRD:   next = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:   next = bus.mem_ready ? FETCH : MEMWR;
            RTYPEEX: next = RTYPEWB;
            ADDIEX:  next = ADDIWB;
            default: next = FETCH;
        endcase
    end
    mc_ctrl_decode u_decode (
        .state     (state),
        .opcode    (bus.opcode),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .reset     (reset),
        .ctrl      (ctrl)
    );
    assign {bus.mem_req, bus.mem_write, bus.ir_write, bus.iord, bus.reg_dst, bus.mem_to_reg,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
            bus.pc_en, bus.illegal_op} = ctrl;
`ifdef MC_PERF_CNT_EN
    // only completing states return to FETCH; DECODE's illegal-op exit is excluded
    logic retire;
    assign retire = next == FETCH && state != FETCH && state != DECODE;
    always_ff @(posedge clk or posedge reset)
        if (reset) retired <= '0;
        else if (retire) retired <= retired + PERF_W'(1);
`endif
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: instruction-level reference model of the multicycle control, driven with random waits.
module tb_mc_main_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mc_main_control_if bus();
`ifdef MC_PERF_CNT_EN
    localparam int PW = 4;
    logic [PW-1:0] retired;
    mc_main_control #(.PERF_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus), .retired(retired));
`else
    mc_main_control dut (.clk(clk), .reset(reset), .bus(bus));
`endif
    int checks = 0;
    int failures = 0;
    int retired_model = 0;
    typedef struct packed {
        logic       req, wr, irw, iord, dst, m2r, rw, asrc;
        logic [1:0] bsrc, aop, psrc;
        logic       pcen, ill;
    } outs_t;
    function automatic outs_t obs();
        return {bus.mem_req, bus.mem_write, bus.ir_write, bus.iord, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                bus.pc_en, bus.illegal_op};
    endfunction
    // Phases: F fetch, D decode, A address, R read, W load-wb, S store, X/Y R-type, B beq, I/K addi, J jump
    function automatic string plan(input logic [5:0] op);
        case (op)
            6'b100011: return "FDARW";
            6'b101011: return "FDAS";
            6'b000000: return "FDXY";
            6'b000100: return "FDB";
            6'b001000: return "FDIK";
            6'b000010: return "FDJ";
            default:   return "FD";
        endcase
    endfunction
    function automatic outs_t model(input byte ph, input logic rdy, input logic z, input logic ill);
        outs_t e = '0;
        case (ph)
            "F": begin e.req = 1'b1; e.bsrc = 2'b01; e.irw = rdy; e.pcen = rdy; end
            "D": begin e.bsrc = 2'b11; e.ill = ill; end
            "A": begin e.asrc = 1'b1; e.bsrc = 2'b10; end
            "R": begin e.req = 1'b1; e.iord = 1'b1; end
            "W": begin e.m2r = 1'b1; e.rw = 1'b1; end
            "S": begin e.req = 1'b1; e.wr = 1'b1; e.iord = 1'b1; end
            "X": begin e.asrc = 1'b1; e.aop = 2'b10; end
            "Y": begin e.dst = 1'b1; e.rw = 1'b1; end
            "B": begin e.asrc = 1'b1; e.aop = 2'b01; e.psrc = 2'b01; e.pcen = z; end
            "I": begin e.asrc = 1'b1; e.bsrc = 2'b10; end
            "K": e.rw = 1'b1;
            "J": begin e.psrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    // Starts and ends at posedge+1; zmode 0/1 fixes zero, 2 randomizes it; stop_after>0 abandons mid-instruction
    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait, input int zmode,
                             input int stop_after, output int cycles);
        string p;
        logic ill;
        bit done;
        p = plan(op);
        ill = p.len() == 2;
        done = 1'b0;
        cycles = 0;
        bus.opcode = op;
        for (int i = 0; i < p.len() && !done; i++) begin
            byte ph;
            bit mem;
            int w;
            ph = p[i];
            mem = ph == "F" || ph == "R" || ph == "S";
            w = ph == "F" ? fwait : mem ? mwait : 0;
            for (int k = 0; k <= w && !done; k++) begin
                bus.mem_ready = mem ? (k == w) : 1'($urandom);
                bus.zero = zmode == 2 ? 1'($urandom) : 1'(zmode);
                @(negedge clk);
                chk($sformatf("out_op%b_%s%0d", op, string'(ph), k), 32'(obs()),
                    32'(model(ph, bus.mem_ready, bus.zero, ill)));
                @(posedge clk);
                #1;
                cycles++;
                done = stop_after > 0 && cycles == stop_after;
            end
        end
        if (!done && !ill) retired_model++;
    endtask
    task automatic chk_retired();
`ifdef MC_PERF_CNT_EN
        chk("retired", 32'(retired), 32'(PW'(retired_model)));
`endif
    endtask
    initial begin
        int cyc;
        logic [5:0] ops [6];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        bus.opcode = 6'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("reset_out", 32'(obs()), 32'(model("F", 1'b0, 1'b0, 1'b0)));
        bus.mem_ready = 1'b1;
        #1;
        chk("reset_ready_no_strobe", 32'(obs()), 32'(model("F", 1'b0, 1'b0, 1'b0)));
        chk_retired();
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        run_instr(6'b000000, 0, 0, 2, 0, cyc);
        chk("lat_r", 32'(cyc), 32'd4);
        run_instr(6'b100011, 0, 0, 2, 0, cyc);
        chk("lat_lw", 32'(cyc), 32'd5);
        run_instr(6'b101011, 0, 0, 2, 0, cyc);
        chk("lat_sw", 32'(cyc), 32'd4);
        run_instr(6'b001000, 0, 0, 2, 0, cyc);
        chk("lat_addi", 32'(cyc), 32'd4);
        run_instr(6'b000010, 0, 0, 2, 0, cyc);
        chk("lat_j", 32'(cyc), 32'd3);
        run_instr(6'b000100, 0, 0, 1, 0, cyc);
        chk("lat_beq_taken", 32'(cyc), 32'd3);
        run_instr(6'b000100, 2, 0, 0, 0, cyc);
        chk("lat_beq_not_taken", 32'(cyc), 32'd5);
        run_instr(6'b100011, 3, 2, 2, 0, cyc);
        chk("lat_lw_stalled", 32'(cyc), 32'd10);
        run_instr(6'b111111, 0, 0, 2, 0, cyc);
        chk("lat_illegal", 32'(cyc), 32'd2);
        chk_retired();
        run_instr(6'b000000, 1, 0, 2, 0, cyc);
        chk_retired();
        // abandon a load while its memory read is stalled
        run_instr(6'b100011, 0, 5, 2, 4, cyc);
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        retired_model = 0;
        #1;
        chk("abort_reset_out", 32'(obs()), 32'(model("F", 1'b0, 1'b0, 1'b0)));
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_held_out", 32'(obs()), 32'(model("F", 1'b0, 1'b0, 1'b0)));
        chk_retired();
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 17; n++) run_instr(6'b001000, 0, 0, 2, 0, cyc);
        chk_retired();
        run_instr(6'b111111, 0, 0, 2, 0, cyc);
        chk_retired();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = $urandom_range(0, 7) == 0 ? 6'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 2, 0, cyc);
            chk_retired();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
